// File: rtl/axil_regbank.sv
// axil_regbank: parametrised AXI4-Lite slave register bank with byte strobes, SLVERR decode and a flat register view.
// Optional feature macro AXIL_REGBANK_W1C_EN turns register NUM_REGS-1 into a write-1-to-clear status register.
module axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [DATA_WIDTH-1:0]          hw_event_i
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(STRB_W);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_W; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic idx_hit(input logic [IDX_W-1:0] idx, input int i);
    return idx == i[IDX_W-1:0];
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) if (idx_hit(idx, i)) r = 1'b1;
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [0:0]            wstate_q, wstate_d, rstate_q, rstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  aw_fire, w_fire, commit, w_ok, r_ok;
  logic [IDX_W-1:0]      cur_idx, ar_idx;
  logic [DATA_WIDTH-1:0] cur_data, cur_mask;

  assign S_AXI_AWREADY = (wstate_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = (wstate_q == W_IDLE) && !w_held_q;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // A channel captured this cycle is used directly so the commit lands on the later handshake edge.
  assign aw_fire  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire   = S_AXI_WVALID && S_AXI_WREADY;
  assign cur_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:OFF_W];
  assign cur_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign cur_mask = strb_mask(w_held_q ? wstrb_q : S_AXI_WSTRB);
  assign commit   = (wstate_q == W_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign w_ok     = in_range(cur_idx);
  assign ar_idx   = S_AXI_ARADDR[ADDR_WIDTH-1:OFF_W];
  assign r_ok     = in_range(ar_idx);

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (wstate_q == W_IDLE) begin
      if (commit) begin
        wstate_d  = W_RESP;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:OFF_W];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
      end
    end else if (S_AXI_BREADY) begin
      wstate_d = W_IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && idx_hit(cur_idx, i)) regs_d[i] = (regs_q[i] & ~cur_mask) | (cur_data & cur_mask);
    end
`ifdef AXIL_REGBANK_W1C_EN
    // Event bits are OR-ed in after the clear so a same-cycle set wins.
    regs_d[NUM_REGS-1] = (regs_q[NUM_REGS-1] &
                          ~((commit && idx_hit(cur_idx, NUM_REGS-1)) ? (cur_data & cur_mask) : '0))
                         | hw_event_i;
`endif
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rstate_q == R_IDLE) begin
      if (S_AXI_ARVALID) begin
        rstate_d = R_DATA;
        rresp_d  = r_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_d  = '0;
        for (int i = 0; i < NUM_REGS; i++) if (idx_hit(ar_idx, i)) rdata_d = regs_q[i];
      end
    end else if (S_AXI_RREADY) begin
      rstate_d = R_IDLE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
`ifdef AXIL_REGBANK_W1C_EN
      regs_q[NUM_REGS-1] <= '0;
`endif
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  logic unused_inputs;
`ifdef AXIL_REGBANK_W1C_EN
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};
`else
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0],
                           hw_event_i};
`endif
endmodule

// File: tb/tb_axil_regbank.sv
// Directed and randomized bench for axil_regbank, checked against a byte-level register-array model.
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam logic [DW-1:0] RST = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [AW-1:0] araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] hw_event = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] regs;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mdl [NR];

  always #5 clk = ~clk;

  axil_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RST_VAL(RST)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs), .hw_event_i(hw_event)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an array of words, addressed by byte address / bytes-per-word.
  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a) / (DW / 8);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    return (idx_of(a) < NR) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    return (idx_of(a) < NR) ? mdl[idx_of(a)] : '0;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RST;
`ifdef AXIL_REGBANK_W1C_EN
    mdl[NR-1] = '0;
`endif
  endtask

  task automatic mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int i;
    i = idx_of(a);
    if (i >= NR) return;
    for (int b = 0; b < DW / 8; b++) begin
      if (s[b]) begin
`ifdef AXIL_REGBANK_W1C_EN
        if (i == NR - 1) mdl[i][8*b +: 8] = mdl[i][8*b +: 8] & ~d[8*b +: 8];
        else
`endif
        mdl[i][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc;
    logic aw_done, w_done, hs_aw, hs_w;
    logic [1:0] er;
    er = exp_resp(a);
    cyc = 0;
    aw_done = 1'b0;
    w_done = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = a;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = d;
      wstrb   = s;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) w_done = 1'b1;
      cyc++;
      if (!(aw_done && w_done)) chk1($sformatf("bvalid_early@%0h", a), bvalid, 1'b0);
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    mdl_write(a, d, s);
    chk1($sformatf("bvalid_lat@%0h", a), bvalid, 1'b1);
    chkr($sformatf("bresp@%0h", a), bresp, er);
    chkf($sformatf("regs_after_wr@%0h", a), regs, mdl_flat());
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      chk1("bvalid_hold", bvalid, 1'b1);
      chkr("bresp_hold", bresp, er);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk1("bvalid_clr", bvalid, 1'b0);
    chk1("awready_re", awready, 1'b1);
    chk1("wready_re", wready, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int r_dly);
    logic [DW-1:0] ed;
    logic [1:0] er;
    ed = exp_rdata(a);
    er = exp_resp(a);
    arvalid = 1'b1;
    araddr = a;
    chk1("arready_idle", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk1($sformatf("rvalid@%0h", a), rvalid, 1'b1);
    chk1("arready_lo", arready, 1'b0);
    chkd($sformatf("rdata@%0h", a), rdata, ed);
    chkr($sformatf("rresp@%0h", a), rresp, er);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      chk1("rvalid_hold", rvalid, 1'b1);
      chkd("rdata_hold", rdata, ed);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk1("rvalid_clr", rvalid, 1'b0);
    chk1("arready_re", arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old_val, rnd_d;
    logic [AW-1:0] rnd_a;
    // Reset state, checked while reset is asserted and after release.
    #1 rst_n = 1'b0;
    #1;
    mdl_reset();
    chkf("reset_regs", regs, mdl_flat());
    chk1("reset_bvalid", bvalid, 1'b0);
    chk1("reset_rvalid", rvalid, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rst_awready", awready, 1'b1);
    chk1("rst_wready", wready, 1'b1);
    chk1("rst_arready", arready, 1'b1);
    chkr("rst_bresp", bresp, 2'b00);
    chkr("rst_rresp", rresp, 2'b00);
    chkd("rst_rdata", rdata, '0);

    // Basic write/readback.
    for (int i = 0; i < NR; i++) do_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);

    // Byte strobes.
    do_write(10'h000, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(10'h000, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(10'h000, 0);
    chkd("strobe_merge", mdl[0], 32'hAA22CC44);
    do_write(10'h004, 32'hFFFF_FFFF, 4'h0, 0, 0, 1);

    // Channel ordering and response back-pressure.
    do_write(10'h008, 32'h0BAD_F00D, 4'hF, 3, 0, 5);
    do_write(10'h004, 32'h1357_9BDF, 4'hF, 0, 3, 5);
    do_read(10'h008, 3);
    do_read(10'h005, 0);

    // Out-of-range accesses.
    do_write(10'h010, 32'h5555_5555, 4'hF, 0, 0, 2);
    do_write(10'h3FC, 32'h6666_6666, 4'hF, 1, 0, 0);
    do_read(10'h010, 1);
    do_read(10'h3FF, 0);

    // Read captured in the write-commit cycle sees the old value.
    old_val = mdl[1];
    awvalid = 1'b1; awaddr = 10'h004; wvalid = 1'b1; wdata = 32'h5A5A_A5A5; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 10'h004;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mdl_write(10'h004, 32'h5A5A_A5A5, 4'hF);
    chkd("rd_during_commit", rdata, old_val);
    chk1("concurrent_bvalid", bvalid, 1'b1);
    chkf("concurrent_regs", regs, mdl_flat());
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(10'h004, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      rnd_a = AW'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
`ifdef AXIL_REGBANK_W1C_EN
      if (idx_of(rnd_a) == NR - 1) rnd_a = 10'h000;
`else
      hw_event = $urandom;
`endif
      rnd_d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(rnd_a, rnd_d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(rnd_a, $urandom_range(0, 3));
    end
    hw_event = '0;
    chkf("random_regs", regs, mdl_flat());

    // Asynchronous reset with both responses outstanding.
    awvalid = 1'b1; awaddr = 10'h008; wvalid = 1'b1; wdata = 32'h7777_0000; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 10'h000;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk1("pre_rst_bvalid", bvalid, 1'b1);
    chk1("pre_rst_rvalid", rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    chk1("async_rst_bvalid", bvalid, 1'b0);
    chk1("async_rst_rvalid", rvalid, 1'b0);
    chkf("async_rst_regs", regs, mdl_flat());
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rel_awready", awready, 1'b1);
    chk1("rel_wready", wready, 1'b1);
    chk1("rel_arready", arready, 1'b1);

    // A pending AW capture is dropped by reset.
    awvalid = 1'b1; awaddr = 10'h008;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk1("aw_pending", awready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("aw_discard", awready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    wvalid = 1'b1; wdata = 32'hC0DE_0001; wstrb = 4'hF;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk1("no_stale_aw", bvalid, 1'b0);
    @(posedge clk); #1;
    chk1("no_stale_aw2", bvalid, 1'b0);
    awvalid = 1'b1; awaddr = 10'h00C;
    @(posedge clk); #1;
    awvalid = 1'b0;
    mdl_write(10'h00C, 32'hC0DE_0001, 4'hF);
    chk1("w_then_aw_bvalid", bvalid, 1'b1);
    chkf("w_then_aw_regs", regs, mdl_flat());
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    do_read(10'h00C, 0);

`ifdef AXIL_REGBANK_W1C_EN
    // Status register: events set, writes of 1 clear, set wins.
    hw_event = 32'h5;
    @(posedge clk); #1;
    hw_event = '0;
    mdl[NR-1] = mdl[NR-1] | 32'h5;
    chkf("w1c_event", regs, mdl_flat());
    awvalid = 1'b1; awaddr = 10'h00C; wvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF;
    hw_event = 32'h1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; hw_event = '0;
    mdl_write(10'h00C, 32'h1, 4'hF);
    mdl[NR-1] = mdl[NR-1] | 32'h1;
    chkd("w1c_set_wins", mdl[NR-1], 32'h5);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    do_read(10'h00C, 0);
    do_write(10'h00C, 32'h4, 4'hF, 0, 0, 0);
    do_read(10'h00C, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
